// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and helpers for the instruction-memory fetch responder.
package imem_fetch_responder_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  // One extra bit so byte limits and addr+4 carries fit without wrapping.
  localparam int unsigned ADDR_XW = ADDR_W + 1;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_e;

  // Per-fetch decode result: err blanks both words, zero_b blanks the second.
  typedef struct packed {
    logic err;
    logic zero_b;
  } fetch_decode_t;

  // True when a byte address falls inside the array.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0]  addr,
                                         input logic [ADDR_XW-1:0] byte_limit);
    return ({1'b0, addr} < byte_limit);
  endfunction

  // Decode a fetch: misaligned/out-of-range first word is an error; the second
  // word is dropped for single fetches, errors, or when addr+4 (with carry)
  // lies past the array.
  function automatic fetch_decode_t decode_fetch(input logic [ADDR_W-1:0]  addr,
                                                 input logic               single,
                                                 input logic [ADDR_XW-1:0] byte_limit);
    fetch_decode_t      dec;
    logic [ADDR_XW-1:0] addr_b;
    addr_b     = {1'b0, addr} + ADDR_XW'(4);
    dec.err    = (addr[1:0] != 2'b00) || !addr_in_range(addr, byte_limit);
    dec.zero_b = dec.err || single || (addr_b >= byte_limit);
    return dec;
  endfunction

endpackage

// File: rtl/imem_fetch_responder_imem_array.sv
// Instruction word array: one write port, two synchronous read ports.
// A write and a read of the same word on one edge return the old word.
module imem_array
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_a_i,
  input  logic               zero_a_i,
  input  logic [AW-1:0]      raddr_b_i,
  input  logic               zero_b_i,
  output logic [INSTR_W-1:0] rdata_a_o,
  output logic [INSTR_W-1:0] rdata_b_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH_WORDS];
  logic [INSTR_W-1:0] rdata_a_q;
  logic [INSTR_W-1:0] rdata_b_q;

  // Loader write port; storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read registers double as the response output registers; zero requests blank a port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_a_q <= NOP_INSTR;
      rdata_b_q <= NOP_INSTR;
    end else if (re_i) begin
      rdata_a_q <= zero_a_i ? NOP_INSTR : mem_q[raddr_a_i];
      rdata_b_q <= zero_b_i ? NOP_INSTR : mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: accepts one fetch, returns one or two
// words a fixed number of cycles later and holds them until consumed.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_single,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [INSTR_W-1:0] Instr1_fIM,
  output logic [INSTR_W-1:0] Instr2_fIM,
  output logic               resp_err,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_XW-1:0] BYTE_LIMIT = ADDR_XW'(DEPTH_WORDS) << 2;
  // Counter holds cycles remaining until resp_valid; the read fires when one is left.
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_READ = CW'(1);
  // With a one-cycle latency the array is read on the accepting edge itself.
  localparam bit READ_ON_ACCEPT = (LATENCY == 1);

  fetch_state_e        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                single_q, single_d;
  logic                resp_valid_q;
  logic                req_ready_q;
  logic                err_q;

  logic                rd_en_c;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic                rd_single_c;
  fetch_decode_t       dec_c;
  logic [AW-1:0]       rd_idx_a_c;
  logic [AW-1:0]       rd_idx_b_c;
  logic                load_we_c;

  // Next-state, wait counter and array-read control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    single_d    = single_q;
    rd_en_c     = 1'b0;
    rd_addr_c   = addr_q;
    rd_single_c = single_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d   = req_addr;
          single_d = req_single;
          if (READ_ON_ACCEPT) begin
            rd_en_c     = 1'b1;
            rd_addr_c   = req_addr;
            rd_single_c = req_single;
            state_d     = ST_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CNT_READ) begin
            rd_en_c = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        // A flush coinciding with the handshake simply retires the response.
        if (flush || resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address decode for the word pair being read this cycle.
  always_comb begin
    dec_c      = decode_fetch(rd_addr_c, rd_single_c, BYTE_LIMIT);
    rd_idx_a_c = rd_addr_c[AW+1:2];
    // Wrap of the second index is harmless: such a word is blanked by zero_b.
    rd_idx_b_c = rd_idx_a_c + AW'(1);
    load_we_c  = load_en && addr_in_range(load_addr, BYTE_LIMIT);
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      single_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      single_q     <= single_d;
      resp_valid_q <= (state_d == ST_RESP);
      req_ready_q  <= (state_d == ST_IDLE);
      if (rd_en_c) begin
        err_q <= dec_c.err;
      end
    end
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .we_i      (load_we_c),
    .waddr_i   (load_addr[AW+1:2]),
    .wdata_i   (load_data),
    .re_i      (rd_en_c),
    .raddr_a_i (rd_idx_a_c),
    .zero_a_i  (dec_c.err),
    .raddr_b_i (rd_idx_b_c),
    .zero_b_i  (dec_c.zero_b),
    .rdata_a_o (Instr1_fIM),
    .rdata_b_o (Instr2_fIM)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = err_q;

endmodule
